// File: rtl/sdpb_reader.sv
// Streams a range of a circular SDPB buffer out through a valid/ready port.
// Optional m_last output is enabled by defining SDPB_READER_LAST_EN.
module sdpb_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [ADDR_W-1:0] adb,
  output logic              ceb,
  output logic              oce,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef SDPB_READER_LAST_EN
  output logic              m_last,
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   rd_left;
  logic [ADDR_W:0]   len_eff;
  logic [1:0]        count;
  logic              rd_pend;
  logic [DATA_W-1:0] buf0, buf1;
  logic [2:0]        occ;
  logic              pop, issue, last_issue, final_pop, kill, accept, empty_start;

  assign len_eff     = (length > FULL_LEN) ? FULL_LEN : length;
  assign m_valid     = (count != 2'd0);
  assign m_data      = buf0;
  assign pop         = m_valid && m_ready;
  assign occ         = {1'b0, count} + {2'b00, rd_pend};
  assign kill        = abort && (state != IDLE);
  assign accept      = (state == IDLE) && start && (length != '0);
  assign empty_start = (state == IDLE) && start && (length == '0);
  assign final_pop   = (state == DRAIN) && pop && (count == 2'd1) && !rd_pend;
  assign last_issue  = issue && (rd_left == ONE_LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    if (abort) state_nxt = IDLE;
               else if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (abort || final_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A read may issue when the slot it will land in is guaranteed free,
  // counting the byte already in flight and any pop happening now.
  always_comb begin
    issue = (state == READ) && !abort &&
            ((occ < 3'd2) || (pop && (occ < 3'd3)));
    ceb   = issue;
    busy  = (state != IDLE);
    oce   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adb     <= '0;
      rd_left <= '0;
      rd_pend <= 1'b0;
      count   <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
      done    <= 1'b0;
    end else begin
      done <= empty_start || (final_pop && !abort);
      if (kill) begin
        rd_left <= '0;
        rd_pend <= 1'b0;
        count   <= 2'd0;
      end else begin
        if (accept) begin
          adb     <= start_addr;
          rd_left <= len_eff;
        end else if (issue) begin
          adb     <= adb + 1'b1;
          rd_left <= rd_left - ONE_LEN;
        end
        rd_pend <= issue;
        case ({rd_pend, pop})
          2'b10: begin
            if (count == 2'd0) buf0 <= dout;
            else               buf1 <= dout;
            count <= count + 2'd1;
          end
          2'b01: begin
            buf0  <= buf1;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) buf0 <= dout;
            else begin
              buf0 <= buf1;
              buf1 <= dout;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SDPB_READER_LAST_EN
  logic rd_last, last0, last1;

  assign m_last = m_valid && last0;

  // Last-byte tags travel alongside the data through the same two slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_last <= 1'b0;
      last0   <= 1'b0;
      last1   <= 1'b0;
    end else if (kill) begin
      rd_last <= 1'b0;
      last0   <= 1'b0;
      last1   <= 1'b0;
    end else begin
      rd_last <= last_issue;
      case ({rd_pend, pop})
        2'b10: begin
          if (count == 2'd0) last0 <= rd_last;
          else               last1 <= rd_last;
        end
        2'b01: last0 <= last1;
        2'b11: begin
          if (count == 2'd1) last0 <= rd_last;
          else begin
            last0 <= last1;
            last1 <= rd_last;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sdpb_reader.sv
// Scoreboard bench for sdpb_reader: SDPB memory model, expected-byte queue, negedge monitor.
module tb_sdpb_reader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, m_ready;
  logic [ADDR_W-1:0] start_addr, adb;
  logic [ADDR_W:0]   length;
  logic              ceb, oce, m_valid, busy, done;
  logic [DATA_W-1:0] dout, m_data;
`ifdef SDPB_READER_LAST_EN
  logic              m_last;
`endif

  sdpb_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(rst), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .adb(adb), .ceb(ceb), .oce(oce),
    .dout(dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
`ifdef SDPB_READER_LAST_EN
    .m_last(m_last),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SDPB port B in bypass mode: data appears one clock after the address edge.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q = '0;
  always @(posedge clk) if (ceb) rd_q <= mem[adb];
  assign dout = rd_q;

  typedef struct { logic [DATA_W-1:0] d; logic last; } exp_t;
  exp_t exp_q[$];

  int unsigned vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  int unsigned exp_addr = 0, reads_issued = 0, done_cnt = 0, done_cyc = 0;
  int unsigned hs_cnt = 0, first_hs_cyc = 0, last_hs_cyc = 0, first_valid_cyc = 0;
  int unsigned start_cyc = 0, done_base = 0, reads_base = 0;
  int          occ_m = 0, pend_m = 0;
  logic        valid_seen = 1'b0, prev_stall = 1'b0, abort_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      occ_m = 0;
      pend_m = 0;
    end else begin
      int pop_i;
      exp_t e;
      pop_i = (m_valid && m_ready) ? 1 : 0;
      if (prev_stall && !abort_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
`ifdef SDPB_READER_LAST_EN
        chk("stall_last", m_last, prev_last);
`endif
      end
      if (ceb) begin
        chk("adb", adb, exp_addr);
        chk("ceb_room", (occ_m + pend_m - pop_i) < 2, 1);
        exp_addr = (exp_addr + 1) % DEPTH;
        reads_issued++;
      end
      if (m_valid && !valid_seen) begin
        valid_seen = 1'b1;
        first_valid_cyc = cyc;
      end
      if (pop_i == 1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got m_data=%0d, expected no output", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.d);
`ifdef SDPB_READER_LAST_EN
          chk("m_last", m_last, e.last);
`endif
        end
        hs_cnt++;
        if (hs_cnt == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_in_done", busy, 0);
      end
      occ_m = occ_m + pend_m - pop_i;
      pend_m = ceb ? 1 : 0;
      if (abort && busy) begin
        occ_m = 0;
        pend_m = 0;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
`ifdef SDPB_READER_LAST_EN
      prev_last  = m_last;
`endif
      abort_prev = abort;
    end
  end

  int ready_mode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_ready = !m_ready;
        2:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic issue_start(input int unsigned sa, input int unsigned len);
    int unsigned n;
    n = (len > DEPTH) ? DEPTH : len;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < n; i++) begin
      exp_t e;
      e.d = mem[(sa + i) % DEPTH];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    exp_addr   = sa;
    start_cyc  = cyc;
    done_base  = done_cnt;
    reads_base = reads_issued;
    hs_cnt     = 0;
    valid_seen = 1'b0;
    start      = 1'b1;
    start_addr = sa[ADDR_W-1:0];
    length     = len[ADDR_W:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, input int unsigned n_exp);
    for (int unsigned i = 0; i < budget && done_cnt == done_base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - done_base, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("bytes", hs_cnt, n_exp);
    chk("reads", reads_issued - reads_base, n_exp);
    chk("busy_idle", busy, 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_adb"}, adb, 0);
    chk({tag, "_ceb"}, ceb, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef SDPB_READER_LAST_EN
    chk({tag, "_m_last"}, m_last, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; length = '0;
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = i[DATA_W-1:0];
    #2;
    check_cleared("reset");
    chk("oce", oce, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // basic readout with latency and done timing
    issue_start(10, 4);
    wait_done(50, 4);
    chk("first_valid_lat", first_valid_cyc - start_cyc, 3);
    chk("back_to_back", last_hs_cyc - first_hs_cyc, 3);
    chk("done_after_last", done_cyc - last_hs_cyc, 1);

    // address wrap
    issue_start(510, 4);
    wait_done(50, 4);

    // full buffer with alternating backpressure
    ready_mode = 1;
    issue_start(0, 512);
    wait_done(3000, 512);
    ready_mode = 0;

    // zero length
    issue_start(5, 0);
    chk("zero_len_busy", busy, 0);
    wait_done(20, 0);
    chk("zero_len_done_cyc", done_cyc - start_cyc, 1);
    chk("zero_len_no_valid", valid_seen, 0);

    // oversize length clamps
    issue_start(300, 600);
    wait_done(3000, 512);

    // abort mid-readout, then a fresh readout
    issue_start(100, 8);
    for (int unsigned i = 0; i < 100 && hs_cnt < 3; i++) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - done_base, 0);
    issue_start(0, 2);
    wait_done(50, 2);

    // abort while idle is harmless
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // asynchronous reset mid-readout
    issue_start(200, 50);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_cleared("midreset");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_no_done", done_cnt - done_base, 0);
    issue_start(5, 3);
    wait_done(50, 3);
    chk("post_reset_lat", first_valid_cyc - start_cyc, 3);

    // randomized readouts with random backpressure
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = $urandom_range(0, 255);
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      int unsigned sa, len, sel, n;
      sa  = $urandom_range(0, DEPTH - 1);
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 0;
      else if (sel == 1) len = $urandom_range(513, 1023);
      else               len = $urandom_range(1, 40);
      n = (len > DEPTH) ? DEPTH : len;
      issue_start(sa, len);
      wait_done(4000, n);
    end
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdpb_reader.md
SDPB_READER -- requirements
Module: sdpb_reader

Interface
REQ-001 Parameter ADDR_W, default 9, SDPB read-port address width (512 entries).
REQ-002 Parameter DATA_W, default 8, SDPB read-port data width.
REQ-003 clk  input  1  single clock; the SDPB read port (clkb) shares it.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a readout; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first buffer address to read (circular-buffer tail).
REQ-007 length  input  ADDR_W+1  byte count; 0 means none, values >2^ADDR_W clamp to 2^ADDR_W.
REQ-008 abort  input  1  synchronous cancel of the current readout.
REQ-009 adb  output  ADDR_W  SDPB port-B address.
REQ-010 ceb  output  1  SDPB port-B clock enable; high only in cycles issuing a read.
REQ-011 oce  output  1  SDPB output clock enable; constant 1.
REQ-012 dout  input  DATA_W  SDPB port-B data, valid one clock after the address edge (bypass read mode).
REQ-013 m_data  output  DATA_W  output stream data.
REQ-014 m_valid  output  1  output stream valid.
REQ-015 m_ready  input  1  output stream ready from the downstream consumer (e.g. UART TX).
REQ-016 busy  output  1  readout in progress.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 FSM states: IDLE, READ (issuing addresses), DRAIN (all reads issued, buffer not yet empty).
REQ-019 IDLE->READ on start with length!=0; start with length==0 produces a done pulse in the following cycle, with no reads and busy held low.
REQ-020 start while busy is ignored.
REQ-021 Read addresses are start_addr, start_addr+1, ... modulo 2^ADDR_W; 511 wraps to 0.
REQ-022 Exactly min(length, 2^ADDR_W) reads are issued per readout; no duplicates, no skips.
REQ-023 The returned data is captured into an internal 2-entry output buffer that drives m_data and m_valid.
REQ-024 A read is issued only if buffer occupancy plus in-flight reads, minus any pop in the same cycle, is <2; no byte is ever dropped.
REQ-025 With m_ready held high the block sustains 1 byte per cycle, and the first m_valid occurs in the 3rd cycle after the start edge.
REQ-026 Handshake: transfer occurs when m_valid && m_ready, and m_data/m_valid remain stable while m_valid && !m_ready.
REQ-027 READ->DRAIN once the last read issues; DRAIN->IDLE on the final handshake, with done pulsing in the next cycle.
REQ-028 busy is high from the cycle after start acceptance through the final handshake, and is low in the done cycle.
REQ-029 abort in READ or DRAIN causes the following on the next edge: the FSM returns to IDLE, the buffer and in-flight data are flushed, m_valid goes 0, and no done pulse is generated.
REQ-030 abort in IDLE has no effect.
REQ-031 Simultaneous abort and final handshake: the byte transfers and abort wins, so no done pulse is generated.

Reset
REQ-032 While reset is high: state=IDLE, adb=0, ceb=0, m_valid=0, m_data=0, busy=0, done=0, buffer empty; the outputs are cleared immediately, without waiting for a clock edge.
REQ-033 Reset asserted mid-readout abandons the readout without a done pulse; the first start after deassertion behaves as a start from power-up.

Configuration
REQ-034 Macro SDPB_READER_LAST_EN defined: an extra output m_last (1 bit) is present, high together with m_valid on the final byte of the readout only, and stable under backpressure; m_last is 0 on reset.
REQ-035 Macro SDPB_READER_LAST_EN undefined: the m_last port and its logic are absent, and all other behaviour is identical.

Verification
REQ-036 Buffer preloaded with mem[i]=i; start_addr=10, length=4, m_ready=1 -> m_data 10,11,12,13 on consecutive cycles, first valid 3 cycles after start, done 1 cycle after byte 13.
REQ-037 start_addr=510, length=4 -> adb sequence 510,511,0,1; m_data 0xFE,0xFF,0x00,0x01.
REQ-038 length=512, m_ready toggling 1/0 each cycle -> all 512 bytes delivered in order, none lost or repeated, m_data stable while stalled, ceb never issues a read with the buffer full.
REQ-039 length=0 -> no ceb pulses, m_valid stays 0, done pulses once on the next cycle; length=600 -> exactly 512 bytes delivered.
REQ-040 abort after 3 of 8 bytes -> m_valid 0 next cycle, no done pulse; a new start (addr 0, length 2) then yields 0x00,0x01 and a done pulse.
REQ-041 Reset pulse mid-readout -> outputs clear without waiting for a clock edge; with SDPB_READER_LAST_EN, m_last is high only on byte 13 in scenario REQ-036.
